// File: rtl/conv_1st_feeder_if.sv
// Load-side bundle between the stream sources, conv_1st_feeder and the conv_1st_top scan/bias/sta inputs.
// The feeder takes the master modport; the stream sources and the conv controller take the slave modport.
interface conv_1st_feeder_if;
    logic        frame_req;
    logic        bias_upd;
    logic        pix_valid;
    logic [7:0]  pix_data;
    logic        pix_ready;
    logic        bias_valid;
    logic [15:0] bias_data;
    logic        bias_ready;
    logic        frame_done;
    logic [39:0] scan;
    logic [23:0] bias;
    logic        sta;
    logic        busy;

    modport master (
        input  frame_req, bias_upd, pix_valid, pix_data, bias_valid, bias_data, frame_done,
        output pix_ready, bias_ready, scan, bias, sta, busy
    );

    modport slave (
        output frame_req, bias_upd, pix_valid, pix_data, bias_valid, bias_data, frame_done,
        input  pix_ready, bias_ready, scan, bias, sta, busy
    );
endinterface

// File: rtl/conv_1st_feeder.sv
// Packs pixel bytes into 40-bit scan words and biases into 24-bit bias words, then launches the conv.
// Optional CONV1_FEED_PARK_EN: non-write cycles drive parking addresses instead of holding the last word.
module conv_1st_feeder #(
    parameter int N_PIX  = 300,
    parameter int N_BIAS = 34
) (
    input  logic               clk,
    input  logic               rst_n,
    conv_1st_feeder_if.master  bus
);
    localparam int          N_WORDS    = N_PIX / 4;
    localparam logic [6:0]  LAST_WADDR = 7'(N_WORDS - 1);
    localparam logic [5:0]  LAST_BIDX  = 6'(N_BIAS - 1);
    localparam logic [39:0] SCAN_PARK  = {32'h0, 1'b0, 7'h7F};
    localparam logic [23:0] BIAS_PARK  = {16'h0, 2'b00, 6'h3F};

    typedef enum logic [2:0] {IDLE, LD_BIAS, LD_PIX, START, RUN} state_t;

    state_t      state, state_nxt;
    logic [1:0]  lane;
    logic [23:0] part;
    logic [6:0]  waddr;
    logic [5:0]  bidx;
    logic [39:0] scan_q;
    logic [23:0] bias_q;
    logic        sta_q;

    logic pix_acc, bias_acc, word_done, last_word, last_bias;

    assign pix_acc   = bus.pix_valid && (state == LD_PIX);
    assign bias_acc  = bus.bias_valid && (state == LD_BIAS);
    assign word_done = pix_acc && (lane == 2'd3);
    assign last_word = word_done && (waddr == LAST_WADDR);
    assign last_bias = bias_acc && (bidx == LAST_BIDX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        bus.pix_ready  = 1'b0;
        bus.bias_ready = 1'b0;
        bus.busy       = 1'b1;
        case (state)
            IDLE: begin
                bus.busy = 1'b0;
                if (bus.frame_req) state_nxt = bus.bias_upd ? LD_BIAS : LD_PIX;
            end
            LD_BIAS: begin
                bus.bias_ready = 1'b1;
                if (last_bias) state_nxt = LD_PIX;
            end
            LD_PIX: begin
                bus.pix_ready = 1'b1;
                if (last_word) state_nxt = START;
            end
            START:   state_nxt = RUN;
            RUN:     if (bus.frame_done) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // sta lags START by a register so it rises one cycle after the last scan word is on the bus.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sta_q <= 1'b0;
        end else begin
            sta_q <= (state == START) || ((state == RUN) && !bus.frame_done);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lane  <= 2'd0;
            part  <= 24'h0;
            waddr <= 7'd0;
        end else if (pix_acc) begin
            lane <= lane + 2'd1;
            case (lane)
                2'd0:    part[7:0]   <= bus.pix_data;
                2'd1:    part[15:8]  <= bus.pix_data;
                2'd2:    part[23:16] <= bus.pix_data;
                default: part        <= part;
            endcase
            if (word_done) waddr <= last_word ? 7'd0 : waddr + 7'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scan_q <= SCAN_PARK;
        end else if (word_done) begin
            scan_q <= {bus.pix_data, part, 1'b0, waddr};
        end else begin
`ifdef CONV1_FEED_PARK_EN
            scan_q <= SCAN_PARK;
`else
            scan_q <= scan_q;
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bias_q <= BIAS_PARK;
            bidx   <= 6'd0;
        end else if (bias_acc) begin
            bias_q <= {bus.bias_data, 2'b00, bidx};
            bidx   <= last_bias ? 6'd0 : bidx + 6'd1;
        end else begin
`ifdef CONV1_FEED_PARK_EN
            bias_q <= BIAS_PARK;
`else
            bias_q <= bias_q;
`endif
        end
    end

    assign bus.scan = scan_q;
    assign bus.bias = bias_q;
    assign bus.sta  = sta_q;
endmodule
